// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// loads the IF/ID pipeline register, honouring stall, flush and branch redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'hE1A0_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             branch_taken,
  input  logic [31:0]      branch_addr,
  input  logic             flush,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_inst,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_inst,
  output logic             id_valid,
  output logic [CNT_W-1:0] fetch_count
);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc_plus4;
  logic [31:0]      id_pc_q, id_pc_d;
  logic [31:0]      id_inst_q, id_inst_d;
  logic             id_valid_q, id_valid_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
  logic             accept;

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    accept   = !flush && !freeze;

    // Redirect wins over a stall; the target is word-aligned by masking.
    pc_d = pc_plus4;
    if (branch_taken) begin
      pc_d = branch_addr & ~32'h0000_0003;
    end else if (freeze) begin
      pc_d = pc_q;
    end

    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    if (flush) begin
      id_pc_d    = '0;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else if (accept) begin
      id_pc_d    = pc_plus4;
      id_inst_d  = imem_inst;
      id_valid_d = 1'b1;
    end

    fetch_count_d = fetch_count_q;
    if (accept && (fetch_count_q != '1)) begin
      fetch_count_d = fetch_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      id_pc_q       <= '0;
      id_inst_q     <= NOP_INST;
      id_valid_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      id_pc_q       <= id_pc_d;
      id_inst_q     <= id_inst_d;
      id_valid_q    <= id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_pc       = id_pc_q;
  assign id_inst     = id_inst_q;
  assign id_valid    = id_valid_q;
  assign fetch_count = fetch_count_q;

endmodule
